// File: rtl/cva5_types.sv
// Shared types for the retire trace capture block: core retire record, captured entry, FSM state.
package cva5_types;

    localparam int TRACE_SEQ_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        valid;
    } trace_retire_outputs_t;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            instruction;
        logic [TRACE_SEQ_W-1:0] seq;
    } trace_capture_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } trace_capture_state_t;

endpackage

// File: rtl/trace_capture_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: write visible on read port after the write edge; backpressure: none.
module trace_capture_ram
    import cva5_types::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  trace_capture_entry_t wdata,
    input  logic [AW-1:0]        raddr,
    output trace_capture_entry_t rdata
);

    trace_capture_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_retire_capture.sv
// Captures retired instructions into a FWFT buffer with seq tagging, drop counting and stop-on-full.
// Latency: entry written at edge N is readable after edge N; backpressure: rd_valid/rd_ready, losses counted.
module trace_retire_capture
    import cva5_types::*;
#(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  trace_retire_outputs_t retire,
    input  logic                  enable,
    input  logic                  stop_on_full,
    input  logic                  clear,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output trace_capture_entry_t  rd_entry,
    output logic                  overflow,
    output logic [SEQ_W-1:0]      drop_count,
    output trace_capture_state_t  state
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic [SEQ_W-1:0]     drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    trace_capture_state_t state_q, state_d;

    logic                 full;
    logic                 pop;
    logic                 active;
    logic                 wr_en;
    logic                 lost;
    trace_capture_entry_t wr_entry;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign pop    = rd_valid && rd_ready;
    assign active = (state_q != IDLE);
    // A same-cycle pop frees the slot the write is about to take.
    assign wr_en  = (state_q == RUN) && retire.valid && (!full || pop);
    assign lost   = active && retire.valid && !wr_en;

    assign wr_entry.pc          = retire.pc;
    assign wr_entry.instruction = retire.instruction;
    assign wr_entry.seq         = TRACE_SEQ_W'(seq_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        state_d  = state_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            seq_d    = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
            state_d  = IDLE;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (active && retire.valid) begin
                seq_d = seq_q + 1'b1;
            end
            if (lost) begin
                ovf_d  = 1'b1;
                drop_d = (drop_q == '1) ? drop_q : drop_q + 1'b1;
            end
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN: begin
                    if (lost && stop_on_full) begin
                        state_d = STOPPED;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end
                end
                STOPPED: state_d = STOPPED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    trace_capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && !clear),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign rd_valid   = (count_q != '0);
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign state      = state_q;

endmodule

// File: tb/tb_trace_retire_capture.sv
module tb_trace_retire_capture;
    import cva5_types::*;

    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    trace_retire_outputs_t retire;
    logic                  enable, stop_on_full, clear, rd_ready;
    logic                  rd_valid, overflow;
    trace_capture_entry_t  rd_entry;
    logic [SEQ_W-1:0]      drop_count;
    trace_capture_state_t  state;

    trace_retire_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst_n(rst_n), .retire(retire), .enable(enable),
        .stop_on_full(stop_on_full), .clear(clear), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_entry(rd_entry), .overflow(overflow),
        .drop_count(drop_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int npop = 0;
    trace_capture_entry_t sb[$];
    trace_capture_entry_t last_pop;

    int                   m_cnt;
    logic [SEQ_W-1:0]     m_seq, m_drop;
    logic                 m_ovf;
    trace_capture_state_t m_state;

    typedef struct {
        logic en; logic v; logic [31:0] pc; logic rdy;
        logic exp_rdv; trace_capture_state_t exp_st;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_seq = '0; m_drop = '0; m_ovf = 1'b0; m_state = IDLE;
        sb.delete();
    endtask

    // One clock cycle: drive, check the head before the edge, advance the model, check after the edge.
    task automatic step(input logic en, input logic v, input logic [31:0] pc,
                        input logic rdy, input logic sof, input logic clr);
        logic pop, wr, act;
        trace_capture_entry_t e;
        enable = en; retire.valid = v; retire.pc = pc; retire.instruction = ~pc;
        rd_ready = rdy; stop_on_full = sof; clear = clr;
        #1;
        chk("rd_valid_pre", rd_valid, m_cnt != 0);
        pop = (m_cnt != 0) && rdy;
        if (pop && !clr) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rd_entry", rd_entry, e);
                last_pop = rd_entry;
                npop++;
            end
        end
        if (clr) begin
            model_reset();
        end else begin
            act = (m_state != IDLE);
            wr  = (m_state == RUN) && v && (m_cnt < DEPTH || pop);
            if (wr) begin
                e.pc = pc; e.instruction = ~pc; e.seq = m_seq;
                sb.push_back(e);
            end
            if (act && v && !wr) begin
                m_ovf = 1'b1;
                if (m_drop != '1) m_drop = m_drop + 1'b1;
            end
            if (act && v) m_seq = m_seq + 1'b1;
            m_cnt = m_cnt + int'(wr) - int'(pop);
            case (m_state)
                IDLE: if (en) m_state = RUN;
                RUN:  if (act && v && !wr && sof) m_state = STOPPED;
                      else if (!en) m_state = IDLE;
                default: ;
            endcase
        end
        @(posedge clk); #1;
        chk("state", state, m_state);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        retire.valid = 1'b0; rd_ready = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int p0;
        tbl[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, RUN};
        tbl[1] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b1, RUN};
        tbl[2] = '{1'b1, 1'b1, 32'h104, 1'b0, 1'b1, RUN};
        tbl[3] = '{1'b1, 1'b1, 32'h108, 1'b0, 1'b1, RUN};
        tbl[4] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, RUN};
        tbl[5] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, RUN};
        tbl[6] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, RUN};

        rst_n = 1'b0; enable = 0; stop_on_full = 0; clear = 0; rd_ready = 0;
        retire = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_state", state, IDLE);
        chk("rst_drop", drop_count, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle: retires ignored
        step(0, 1, 32'h50, 0, 0, 0);
        chk("idle_no_capture", rd_valid, 0);

        // Basic capture, table driven
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].v, tbl[i].pc, tbl[i].rdy, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].exp_rdv);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].exp_st);
        end
        chk("basic_last_seq", last_pop.seq, 16'd2);
        chk("basic_last_pc", last_pop.pc, 32'h108);
        chk("basic_overflow", overflow, 0);

        // Fill then drop, keep running
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 32'h1000 + 32'(i * 4), 0, 0, 0);
        chk("fill_drop_count", drop_count, 16'd4);
        chk("fill_overflow", overflow, 1);
        chk("fill_state", state, RUN);
        p0 = npop;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0);
        chk("fill_drained", npop - p0, 16);
        chk("fill_last_seq", last_pop.seq, 16'd15);
        step(1, 1, 32'h2000, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("fill_next_seq", last_pop.seq, 16'd20);

        // Stop on full
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) step(1, 1, 32'h3000 + 32'(i * 4), 0, 1, 0);
        chk("stop_state", state, STOPPED);
        chk("stop_drop", drop_count, 16'd1);
        p0 = npop;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 1, 0);
        chk("stop_drained", npop - p0, 16);
        chk("stop_empty", rd_valid, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 32'h4000, 0, 1, 0);
        chk("stop_drop_more", drop_count, 16'd4);
        chk("stop_no_write", rd_valid, 0);

        // Simultaneous pop and write on a full buffer
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 32'h5000 + 32'(i * 4), 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h6000 + 32'(i * 4), 1, 0, 0);
        chk("popwr_drop", drop_count, 16'd0);
        p0 = npop;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0);
        chk("popwr_occupancy", npop - p0, 16);
        chk("popwr_empty", rd_valid, 0);

        // Clear beats same-cycle retire and pop
        for (int i = 0; i < 3; i++) step(1, 1, 32'h7000 + 32'(i * 4), 0, 0, 0);
        step(1, 1, 32'h7100, 1, 0, 1);
        chk("clr_rd_valid", rd_valid, 0);
        chk("clr_drop", drop_count, 0);
        chk("clr_state", state, IDLE);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h7200, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("clr_seq_zero", last_pop.seq, 16'd0);

        // Async reset between edges with 5 entries buffered
        for (int i = 0; i < 5; i++) step(1, 1, 32'h8000 + 32'(i * 4), 0, 0, 0);
        chk("areset_pre_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_rd_valid", rd_valid, 0);
        chk("areset_state", state, IDLE);
        chk("areset_drop", drop_count, 0);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        step(1, 0, 0, 1, 0, 0);
        chk("areset_after", rd_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_retire_capture.md
TRACE_RETIRE_CAPTURE -- requirements
Module: trace_retire_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16: buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter SEQ_W, default 16: width of the sequence and drop counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port retire, input, trace_retire_outputs_t: pc, instruction and valid of each retired instruction from the core.
REQ-006 SHALL have port enable, input, 1 bit: capture enable.
REQ-007 SHALL have port stop_on_full, input, 1 bit: 1 = stop capturing when full; 0 = drop while full and keep running.
REQ-008 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-009 SHALL have port rd_valid, output, 1 bit: head entry available.
REQ-010 SHALL have port rd_ready, input, 1 bit: consumer accepts the head entry.
REQ-011 SHALL have port rd_entry, output, trace_capture_entry_t: head entry's pc, instruction and seq.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when any retire is lost.
REQ-013 SHALL have port drop_count, output, SEQ_W bits: number of lost retires, saturating.
REQ-014 SHALL have port state, output, trace_capture_state_t: current FSM state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and STOPPED.
REQ-016 SHALL make these transitions, with clear taking priority over all of them:
- IDLE -> RUN when enable=1.
- RUN -> IDLE when enable=0.
- RUN -> STOPPED when an accepted-eligible retire meets a full buffer with no same-cycle pop and stop_on_full=1.
- STOPPED -> IDLE only on clear.
REQ-017 SHALL increment the seq counter by 1 for every retire.valid=1 cycle while in RUN or STOPPED, whether captured or lost; the counter wraps modulo 2^SEQ_W.
REQ-018 SHALL write {pc, instruction, current seq} at the tail when in RUN, retire.valid=1, and the buffer is not full.
REQ-019 SHALL treat a buffer that is full but popped in the same cycle as not full: the write is accepted and occupancy is unchanged.
REQ-020 SHALL handle a retire that is not written while in RUN or STOPPED as lost: drop_count += 1 (saturating at all ones) and overflow <= 1.
REQ-021 SHALL NOT capture or count anything in IDLE; seq does not advance.
REQ-022 SHALL read first-word-fall-through: rd_valid = (occupancy != 0); rd_entry reflects the head combinationally from registered pointers.
REQ-023 SHALL pop when rd_valid && rd_ready; pops are permitted in every state, including STOPPED.
REQ-024 SHALL, on clear, zero the pointers, occupancy, seq, drop_count and overflow, and set state to IDLE; any same-cycle write or pop is ignored.
REQ-025 SHALL keep occupancy as a counter of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-026 SHALL have capture latency as follows: an entry written at edge N is visible on rd_valid/rd_entry after edge N.
REQ-027 SHALL have no combinational path from retire or enable to any output.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously set state=IDLE, rd_valid=0, overflow=0, drop_count=0, seq=0, and pointers and occupancy to 0; storage contents are don't-care.
REQ-029 SHALL, on reset asserted mid-operation, discard all buffered entries with no partial pop or write.

Structure
REQ-030 SHALL define trace_capture_entry_t ({pc[31:0], instruction[31:0], seq}) and the trace_capture_state_t enum in cva5_types, with the seq width fixed at 16 in the package.
REQ-031 SHALL place storage in one sub-module, trace_capture_ram: DEPTH x entry, one synchronous write port and one asynchronous read port, no reset.

Verification
REQ-032 SHALL cover basic capture: enable=1, 3 retires (pc 0x100/0x104/0x108), rd_ready=1 -> three entries in order with seq 0, 1, 2; overflow=0.
REQ-033 SHALL cover fill then drop: DEPTH=16, stop_on_full=0, rd_ready=0, 20 retires -> 16 entries with seq 0..15, drop_count=4, overflow=1, state=RUN; after draining, the next retire has seq 20.
REQ-034 SHALL cover stop on full: stop_on_full=1, 17 retires, rd_ready=0 -> state=STOPPED after the 17th, drop_count=1; a drain yields 16 entries; further retires give drop_count+1 each, no writes.
REQ-035 SHALL cover simultaneous pop and write: full buffer, rd_ready=1 with retire.valid=1 for 5 cycles -> occupancy stays 16, drop_count=0.
REQ-036 SHALL cover clear priority: clear=1 in the same cycle as a retire and a pop -> next cycle rd_valid=0, seq=0, drop_count=0, state=IDLE.
REQ-037 SHALL cover async reset: rst_n pulsed low between edges with 5 entries buffered -> rd_valid=0 immediately, state=IDLE, no clock required.
